// File: rtl/dmem_pkg.sv
// Shared data-memory constants and copy-engine state encoding.
// Imported by the copy engine and anything sized against the memory.
package dmem_pkg;

  localparam int DMEM_DEPTH = 100;
  localparam int ST_W       = 3;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/dmem_copy_engine.sv
// DMA-style word copier driving the data memory port.
// Forward word-by-word copy: one read cycle then one write cycle per word.
module dmem_copy_engine
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = DMEM_DEPTH,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_A,
  output logic [DATA_W-1:0] mem_WD,
  output logic              mem_WE,
  input  logic [DATA_W-1:0] mem_RD
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [ADDR_W:0] src_end;
  logic [ADDR_W:0] dst_end;
  logic            oob;

  // One extra bit so a huge base address cannot wrap past the limit
  assign src_end = {1'b0, src_addr} + (ADDR_W+1)'(length);
  assign dst_end = {1'b0, dst_addr} + (ADDR_W+1)'(length);
  assign oob     = (src_end > LIMIT) || (dst_end > LIMIT);

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d = src_addr;
          dst_d = dst_addr;
          cnt_d = length;
          if (length == '0)
            state_d = ST_DONE;
          else if (oob)
            state_d = ST_ERR;
          else
            state_d = ST_READ;
        end
      end
      ST_READ: begin
        data_d  = mem_RD;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        src_d = src_q + ADDR_W'(1);
        dst_d = dst_q + ADDR_W'(1);
        cnt_d = cnt_q - LEN_W'(1);
        if (cnt_q == LEN_W'(1))
          state_d = ST_DONE;
        else
          state_d = ST_READ;
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  // Outputs decode registered state only; write data simply holds
  always_comb begin
    mem_A  = '0;
    mem_WE = 1'b0;
    unique case (state_q)
      ST_READ:  mem_A = src_q;
      ST_WRITE: begin
        mem_A  = dst_q;
        mem_WE = 1'b1;
      end
      default: begin
        mem_A  = '0;
        mem_WE = 1'b0;
      end
    endcase
  end

  assign mem_WD = data_q;
  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign err    = (state_q == ST_ERR);

endmodule

// File: doc/dmem_copy_engine.md
Name: dmem_copy_engine

Overview:
Bus initiator that drives the data memory's word-addressed port (A, WD, WE, RD) to copy a block of words from a source address to a destination address. Sits beside the processor datapath as a small DMA-style master. The memory port is muxed to this engine while busy=1; the mux is outside this block. Uses the memory's combinational read and single-cycle synchronous write.

Parameters:
DATA_W, 32, memory word width
ADDR_W, 32, memory address width (word index)
DEPTH, 100, number of memory words; bounds check limit
LEN_W, 8, width of transfer length field

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
src_addr  in  ADDR_W  first source word index
dst_addr  in  ADDR_W  first destination word index
length  in  LEN_W  number of words to copy
busy  out  1  high from the cycle after an accepted start through DONE
done  out  1  one-cycle pulse on successful completion (including length=0)
err  out  1  one-cycle pulse on rejected request; no memory access
mem_A  out  ADDR_W  memory address
mem_WD  out  DATA_W  memory write data
mem_WE  out  1  memory write enable
mem_RD  in  DATA_W  memory combinational read data

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. busy, done, err, mem_WE=0. mem_A, mem_WD, and all internal pointers, counters and data registers =0.
- States: IDLE, READ, WRITE, DONE, ERR.
- IDLE: mem_WE=0, mem_A=0. On a clock edge with start=1, latch src, dst and len:
  - len==0 -> DONE.
  - src+len>DEPTH or dst+len>DEPTH -> ERR. Compute at ADDR_W+1 bits so the sum does not wrap.
  - Otherwise -> READ.
- READ: mem_A=src_ptr, mem_WE=0. At the clock edge, data_reg<=mem_RD. -> WRITE.
- WRITE: mem_A=dst_ptr, mem_WD=data_reg, mem_WE=1. At the clock edge, src_ptr+1, dst_ptr+1, count-1. If count was 1 -> DONE, else -> READ.
- DONE: done=1 for exactly one cycle. -> IDLE.
- ERR: err=1 for exactly one cycle. -> IDLE.
- busy=1 in READ, WRITE, DONE and ERR.
- All outputs are decoded from registered state and registers only; no input-to-output combinational path.
- Throughput: 2 cycles per word. With start sampled at edge 0 and len=N>0, done is high during cycle 2N+1.
- start while busy: ignored and not queued. Inputs are don't-care outside the IDLE sampling edge.
- Overlap: strict forward word-by-word copy. If dst is in (src, src+len), source words are overwritten before being read; the result is the defined replication pattern.
- Reset mid-transfer: aborts immediately and returns to the reset values. Words already written stay written; no done or err pulse.
- mem_WD holds the last data value outside WRITE; only mem_WE qualifies a write.

Decomposition:
- Shared package dmem_pkg:
  - state encoding localparams (IDLE=0, READ=1, WRITE=2, DONE=3, ERR=4; 3 bits)
  - DMEM_DEPTH=100 constant, shared with the data memory
- No sub-module. Single FSM with datapath registers (src_ptr, dst_ptr, count, data_reg).
- The bench instantiates the existing data memory as the responder model.

Test Plan:
- Basic copy: preload mem[10..13]=A0,A1,A2,A3; start src=10 dst=50 len=4 -> mem[50..53]=A0..A3; mem_WE high in 4 cycles; done pulse in cycle 9; busy low after.
- Zero length: start src=5 dst=6 len=0 -> done one cycle after start; mem_WE never asserted; err=0.
- Out of range: start src=98 dst=0 len=3 -> err one-cycle pulse; no mem_WE; memory unchanged. Repeat with dst=97 len=4 -> err.
- Busy ignore: start len=3; pulse start again 2 cycles later with dst=80 -> only the first transfer executes; mem[80] unchanged; exactly one done pulse.
- Overlap: mem[0..3]=7,8,9,10; start src=0 dst=1 len=3 -> mem[0..3]=7,7,7,7.
- Reset mid-copy: len=8; drop rst at cycle 5 (between clock edges) -> busy, mem_WE and mem_A go 0 immediately; no done pulse; new start after release copies correctly.
